// File: rtl/fsm_demux_pkg.sv
// Shared types for the fsm_demux receive path: FSM state encodings and destination codes.
package fsm_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01
  } state_e;

  typedef enum logic {
    DEST_A = 1'b0,
    DEST_B = 1'b1
  } dest_e;

endpackage

// File: rtl/fsm_demux_out_reg.sv
// demux_out_reg: one output channel of fsm_demux, a W-bit data register plus its valid flag.
module demux_out_reg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (set) begin
      q     <= d;
      valid <= 1'b1;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fsm_demux.sv
// fsm_demux: captures a word on load&&enable and delivers it to sink A or B with valid/ready.
// Optional transfer counter output xfer_cnt is enabled by defining FSM_DEMUX_CNT_EN.
module fsm_demux
  import fsm_demux_pkg::*;
#(
  parameter int W = 5
`ifdef FSM_DEMUX_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  input  logic         load,
  input  logic         sel,
  input  logic         enable,
  input  logic         ready_a,
  input  logic         ready_b,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         valid_a,
  output logic         valid_b,
  output logic         busy,
  output logic         overflow
`ifdef FSM_DEMUX_CNT_EN
  , output logic [CNT_W-1:0] xfer_cnt
`endif
);

  state_e state_q, state_d;
  logic   overflow_q, overflow_d;
  logic   set_a, set_b, clr_a, clr_b;
  logic   handshake;
  logic   accept;
  dest_e  dest;

  assign accept = load && enable;
  assign dest   = dest_e'(sel);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    set_a      = 1'b0;
    set_b      = 1'b0;
    clr_a      = 1'b0;
    clr_b      = 1'b0;
    handshake  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          set_a   = (dest == DEST_A);
          set_b   = (dest == DEST_B);
          state_d = SEND;
        end
      end
      SEND: begin
        // Ready on the idle channel is masked by its own valid being low.
        handshake = (valid_a && ready_a) || (valid_b && ready_b);
        if (handshake) begin
          clr_a = valid_a;
          clr_b = valid_b;
          if (accept) begin
            set_a = (dest == DEST_A);
            set_b = (dest == DEST_B);
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        clr_a   = 1'b1;
        clr_b   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // set wins over clr inside the register, which gives back-to-back reuse of a channel.
  demux_out_reg #(.W(W)) u_reg_a (
    .clk   (clk),
    .rst   (rst),
    .set   (set_a),
    .clr   (clr_a),
    .d     (in),
    .q     (out_a),
    .valid (valid_a)
  );

  demux_out_reg #(.W(W)) u_reg_b (
    .clk   (clk),
    .rst   (rst),
    .set   (set_b),
    .clr   (clr_b),
    .d     (in),
    .q     (out_b),
    .valid (valid_b)
  );

  assign busy     = (state_q == SEND);
  assign overflow = overflow_q;

`ifdef FSM_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (handshake) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule
